// File: rtl/pe_sequencer_pkg.sv
// Shared types and sizing for the per-PE convolution sequencer.
// Holds the state encoding, lane counts and the packed PE state word seen by the activation RAM.
package pe_sequencer_pkg;

  localparam int I       = 4;
  localparam int F       = 4;
  localparam int MAX_K   = 4;
  localparam int MAX_C   = 8;
  localparam int MAX_A   = 64;
  localparam int MAX_W   = 64;
  localparam int LAYER_W = 4;

  localparam int K_W = $clog2(MAX_K) + 1;
  localparam int C_W = $clog2(MAX_C) + 1;
  localparam int A_W = $clog2(MAX_A) + 1;
  localparam int W_W = $clog2(MAX_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_COMPUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } pe_state_e;

  typedef struct packed {
    pe_state_e            state;
    logic [LAYER_W-1:0]   layer;
    logic [K_W-1:0]       k;
    logic [C_W-1:0]       c;
    logic [A_W-1:0]       a;
    logic [W_W-1:0]       w;
    logic [A_W-1:0]       remain_a;
    logic [W_W-1:0]       remain_w;
    logic                 flag_a;
    logic                 flag_w;
  } pe_word_t;

endpackage

// File: rtl/pe_sequencer_if.sv
// Host/datapath-facing bundle of the PE sequencer: layer config, handshakes and the PE state word.
interface pe_sequencer_if;
  import pe_sequencer_pkg::*;

  logic               start;
  logic [K_W-1:0]     cfg_num_k;
  logic [C_W-1:0]     cfg_num_c;
  logic [A_W-1:0]     cfg_num_a;
  logic [W_W-1:0]     cfg_num_w;
  logic               dram_last;
  logic               ppu_last;
  logic               mul_ready;

  pe_state_e          state;
  logic [LAYER_W-1:0] cur_layer;
  logic [K_W-1:0]     cur_k;
  logic [C_W-1:0]     cur_c;
  logic [A_W-1:0]     cur_a;
  logic [W_W-1:0]     cur_w;
  logic [A_W-1:0]     remain_a;
  logic [W_W-1:0]     remain_w;
  logic               flag_remain_a;
  logic               flag_remain_w;
  logic               mul_valid;
  logic               layer_done;
  logic               busy;

  modport master (
    output start, cfg_num_k, cfg_num_c, cfg_num_a, cfg_num_w,
           dram_last, ppu_last, mul_ready,
    input  state, cur_layer, cur_k, cur_c, cur_a, cur_w, remain_a, remain_w,
           flag_remain_a, flag_remain_w, mul_valid, layer_done, busy
  );

  modport slave (
    input  start, cfg_num_k, cfg_num_c, cfg_num_a, cfg_num_w,
           dram_last, ppu_last, mul_ready,
    output state, cur_layer, cur_k, cur_c, cur_a, cur_w, remain_a, remain_w,
           flag_remain_a, flag_remain_w, mul_valid, layer_done, busy
  );

endinterface

// File: rtl/pe_seq_counter.sv
// Nested activation/weight/channel stepper for COMPUTE: a wraps into w, w wraps into c,
// and carry marks the step that retires the last input channel.
module pe_seq_counter
  import pe_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           step,
  input  logic [C_W-1:0] num_c,
  input  logic [A_W-1:0] num_a,
  input  logic [W_W-1:0] num_w,
  output logic [C_W-1:0] cur_c,
  output logic [A_W-1:0] cur_a,
  output logic [W_W-1:0] cur_w,
  output logic [A_W-1:0] remain_a,
  output logic [W_W-1:0] remain_w,
  output logic           empty,
  output logic           carry
);

  logic a_wrap, w_wrap, c_last;

  // An empty a or w stream collapses each channel to a single step.
  always_comb begin
    remain_a = num_a - cur_a;
    remain_w = num_w - cur_w;
    empty    = (remain_a == '0) || (remain_w == '0);
    a_wrap   = empty || (remain_a <= A_W'(I));
    w_wrap   = empty || (remain_w <= W_W'(F));
    c_last   = (cur_c == num_c - C_W'(1));
    carry    = step && a_wrap && w_wrap && c_last;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cur_a <= '0;
      cur_w <= '0;
      cur_c <= '0;
    end else if (step) begin
      if (!a_wrap) begin
        cur_a <= cur_a + A_W'(I);
      end else begin
        cur_a <= '0;
        if (!w_wrap) begin
          cur_w <= cur_w + W_W'(F);
        end else begin
          cur_w <= '0;
          cur_c <= c_last ? '0 : cur_c + C_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pe_sequencer.sv
// Per-PE layer FSM: LOAD per output channel, COMPUTE over (c, w, a) groups, WRITEBACK per
// output channel, then bump the layer index that selects the ping-pong activation bank.
module pe_sequencer
  import pe_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  pe_sequencer_if.slave  bus
);

  pe_state_e          state_q, state_d;
  logic [LAYER_W-1:0] layer_q;
  logic [K_W-1:0]     k_q;
  logic               layer_done_q;
  logic [K_W-1:0]     cfg_k;
  logic [C_W-1:0]     cfg_c;
  logic [A_W-1:0]     cfg_a;
  logic [W_W-1:0]     cfg_w;

  logic               accept, k_step, k_last, clr, step, mul_valid;
  logic [C_W-1:0]     cur_c;
  logic [A_W-1:0]     cur_a, remain_a;
  logic [W_W-1:0]     cur_w, remain_w;
  logic               empty, carry;
  pe_word_t           word;

  pe_seq_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .step     (step),
    .num_c    (cfg_c),
    .num_a    (cfg_a),
    .num_w    (cfg_w),
    .cur_c    (cur_c),
    .cur_a    (cur_a),
    .cur_w    (cur_w),
    .remain_a (remain_a),
    .remain_w (remain_w),
    .empty    (empty),
    .carry    (carry)
  );

  assign k_last = (k_q == cfg_k - K_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      layer_q      <= '0;
      k_q          <= '0;
      layer_done_q <= 1'b0;
      cfg_k        <= '0;
      cfg_c        <= '0;
      cfg_a        <= '0;
      cfg_w        <= '0;
    end else begin
      state_q      <= state_d;
      layer_done_q <= (state_q == ST_WRITEBACK) && (state_d == ST_IDLE);
      if (accept) begin
        cfg_k <= bus.cfg_num_k;
        cfg_c <= bus.cfg_num_c;
        cfg_a <= bus.cfg_num_a;
        cfg_w <= bus.cfg_num_w;
        k_q   <= '0;
      end else if (k_step) begin
        k_q <= k_last ? '0 : k_q + K_W'(1);
      end
      if ((state_q == ST_WRITEBACK) && (state_d == ST_IDLE))
        layer_q <= layer_q + LAYER_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (bus.start) state_d = ST_LOAD;
      ST_LOAD:      if (bus.dram_last && k_last) state_d = ST_COMPUTE;
      ST_COMPUTE:   if (carry) state_d = ST_WRITEBACK;
      ST_WRITEBACK: if (bus.ppu_last && k_last) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // mul_ready only gates a real issue; empty streams advance unconditionally.
  always_comb begin
    accept        = (state_q == ST_IDLE) && bus.start;
    k_step        = ((state_q == ST_LOAD) && bus.dram_last) ||
                    ((state_q == ST_WRITEBACK) && bus.ppu_last);
    clr           = (state_q == ST_LOAD) && bus.dram_last && k_last;
    mul_valid     = (state_q == ST_COMPUTE) && !empty;
    step          = (state_q == ST_COMPUTE) && (empty || bus.mul_ready);
    word.state    = state_q;
    word.layer    = layer_q;
    word.k        = k_q;
    word.c        = cur_c;
    word.a        = cur_a;
    word.w        = cur_w;
    word.remain_a = remain_a;
    word.remain_w = remain_w;
    word.flag_a   = (remain_a >= A_W'(I));
    word.flag_w   = (remain_w >= W_W'(F));
  end

  assign bus.state         = word.state;
  assign bus.cur_layer     = word.layer;
  assign bus.cur_k         = word.k;
  assign bus.cur_c         = word.c;
  assign bus.cur_a         = word.a;
  assign bus.cur_w         = word.w;
  assign bus.remain_a      = word.remain_a;
  assign bus.remain_w      = word.remain_w;
  assign bus.flag_remain_a = word.flag_a;
  assign bus.flag_remain_w = word.flag_w;
  assign bus.mul_valid     = mul_valid;
  assign bus.layer_done    = layer_done_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: directed layer scenarios with literal expectations, then random
// traffic, all compared every cycle against a group-count model of the layer schedule.
module tb_pe_sequencer;
  import pe_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_sequencer_if bus();
  pe_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Model: position in the schedule as group indices (ia, iw) and channel c.
  int m_state, m_layer, m_k, m_c, m_ia, m_iw, m_ld, m_nk, m_nc, m_na, m_nw;

  always @(posedge clk) begin
    int st, ly, k, c, ia, iw, ld, nk, nc, na, nw, ga, gw;
    bit adv;
    st = m_state; ly = m_layer; k = m_k; c = m_c; ia = m_ia; iw = m_iw;
    nk = m_nk; nc = m_nc; na = m_na; nw = m_nw; ld = 0;
    if (rst) begin
      st = 0; ly = 0; k = 0; c = 0; ia = 0; iw = 0; nk = 0; nc = 0; na = 0; nw = 0;
    end else begin
      case (st)
        0: if (bus.start) begin
          nk = int'(bus.cfg_num_k); nc = int'(bus.cfg_num_c);
          na = int'(bus.cfg_num_a); nw = int'(bus.cfg_num_w);
          st = 1; k = 0;
        end
        1: if (bus.dram_last) begin
          if (k == nk - 1) begin k = 0; st = 2; c = 0; ia = 0; iw = 0; end
          else k++;
        end
        2: begin
          ga = ceil_div(na, I);
          gw = ceil_div(nw, F);
          adv = (ga == 0) || (gw == 0) || bus.mul_ready;
          if (adv) begin
            if (ga > 0 && gw > 0 && ia < ga - 1) ia++;
            else begin
              ia = 0;
              if (ga > 0 && gw > 0 && iw < gw - 1) iw++;
              else begin
                iw = 0;
                if (c == nc - 1) begin c = 0; st = 3; k = 0; end
                else c++;
              end
            end
          end
        end
        default: if (bus.ppu_last) begin
          if (k == nk - 1) begin k = 0; st = 0; ld = 1; ly = (ly + 1) % (1 << LAYER_W); end
          else k++;
        end
      endcase
    end
    m_state <= st; m_layer <= ly; m_k <= k; m_c <= c; m_ia <= ia; m_iw <= iw; m_ld <= ld;
    m_nk <= nk; m_nc <= nc; m_na <= na; m_nw <= nw;
  end

  always @(negedge clk) begin
    int ea, ew, ra, rw;
    if (checking) begin
      ea = m_ia * I; ew = m_iw * F;
      ra = m_na - ea; rw = m_nw - ew;
      chk("state", int'(bus.state), m_state);
      chk("cur_layer", int'(bus.cur_layer), m_layer);
      chk("cur_k", int'(bus.cur_k), m_k);
      chk("cur_c", int'(bus.cur_c), m_c);
      chk("cur_a", int'(bus.cur_a), ea);
      chk("cur_w", int'(bus.cur_w), ew);
      chk("remain_a", int'(bus.remain_a), ra);
      chk("remain_w", int'(bus.remain_w), rw);
      chk("flag_remain_a", int'(bus.flag_remain_a), int'(ra >= I));
      chk("flag_remain_w", int'(bus.flag_remain_w), int'(rw >= F));
      chk("mul_valid", int'(bus.mul_valid), int'(m_state == 2 && ra != 0 && rw != 0));
      chk("layer_done", int'(bus.layer_done), m_ld);
      chk("busy", int'(bus.busy), int'(m_state != 0));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_layer(input int nk, input int nc, input int na, input int nw);
    bus.cfg_num_k = K_W'(nk);
    bus.cfg_num_c = C_W'(nc);
    bus.cfg_num_a = A_W'(na);
    bus.cfg_num_w = W_W'(nw);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("start_to_load", int'(bus.state), 1);
  endtask

  task automatic finish_wb(input int expect_layer);
    bus.ppu_last = 1'b1;
    cycle();
    bus.ppu_last = 1'b0;
    chk("wb_exit_state", int'(bus.state), 0);
    chk("wb_exit_layer", int'(bus.cur_layer), expect_layer);
    chk("wb_exit_done", int'(bus.layer_done), 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.dram_last = 1'b0; bus.ppu_last = 1'b0; bus.mul_ready = 1'b0;
    bus.cfg_num_k = '0; bus.cfg_num_c = '0; bus.cfg_num_a = '0; bus.cfg_num_w = '0;
    cycle(); cycle();
    rst = 1'b0;
    checking = 1'b1;

    chk("rst_state", int'(bus.state), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_mul_valid", int'(bus.mul_valid), 0);
    chk("rst_layer", int'(bus.cur_layer), 0);
    chk("rst_remain_a", int'(bus.remain_a), 0);
    chk("rst_flag_a", int'(bus.flag_remain_a), 0);

    // Two-k load, then a single channel over three activation groups.
    begin_layer(2, 1, 10, 4);
    bus.mul_ready = 1'b1;
    bus.dram_last = 1'b1;
    cycle();
    chk("load_k1_state", int'(bus.state), 1);
    chk("load_k1", int'(bus.cur_k), 1);
    cycle();
    bus.dram_last = 1'b0;
    chk("load_to_compute", int'(bus.state), 2);
    chk("a0", int'(bus.cur_a), 0);
    chk("ra0", int'(bus.remain_a), 10);
    chk("fa0", int'(bus.flag_remain_a), 1);
    cycle();
    chk("a1", int'(bus.cur_a), 4);
    chk("ra1", int'(bus.remain_a), 6);
    chk("fa1", int'(bus.flag_remain_a), 1);
    cycle();
    chk("a2", int'(bus.cur_a), 8);
    chk("ra2", int'(bus.remain_a), 2);
    chk("fa2", int'(bus.flag_remain_a), 0);
    cycle();
    chk("compute_to_wb", int'(bus.state), 3);
    bus.ppu_last = 1'b1;
    cycle();
    chk("wb_k1", int'(bus.cur_k), 1);
    chk("wb_no_done", int'(bus.layer_done), 0);
    finish_wb(1);
    cycle();
    chk("done_pulse_ends", int'(bus.layer_done), 0);

    // Weight groups nest inside channels.
    begin_layer(1, 2, 4, 8);
    bus.dram_last = 1'b1;
    cycle();
    bus.dram_last = 1'b0;
    chk("cw00_c", int'(bus.cur_c), 0); chk("cw00_w", int'(bus.cur_w), 0);
    cycle();
    chk("cw04_c", int'(bus.cur_c), 0); chk("cw04_w", int'(bus.cur_w), 4);
    cycle();
    chk("cw10_c", int'(bus.cur_c), 1); chk("cw10_w", int'(bus.cur_w), 0);
    cycle();
    chk("cw14_c", int'(bus.cur_c), 1); chk("cw14_w", int'(bus.cur_w), 4);
    cycle();
    chk("cw_to_wb", int'(bus.state), 3);
    finish_wb(2);

    // Stalls hold counters: ready 1,0,0,1 gives 2 issues + 2 stalls.
    begin_layer(1, 1, 8, 4);
    bus.dram_last = 1'b1;
    cycle();
    bus.dram_last = 1'b0;
    chk("stall_valid", int'(bus.mul_valid), 1);
    bus.mul_ready = 1'b1; cycle();
    chk("stall_a_issue", int'(bus.cur_a), 4);
    bus.mul_ready = 1'b0; cycle();
    chk("stall_a_hold1", int'(bus.cur_a), 4);
    cycle();
    chk("stall_a_hold2", int'(bus.cur_a), 4);
    chk("stall_state", int'(bus.state), 2);
    bus.mul_ready = 1'b1; cycle();
    chk("stall_to_wb", int'(bus.state), 3);
    finish_wb(3);

    // Empty activation stream: one cycle per channel, start ignored while busy.
    bus.mul_ready = 1'b0;
    begin_layer(1, 3, 0, 4);
    bus.dram_last = 1'b1;
    cycle();
    bus.dram_last = 1'b0;
    chk("empty_valid", int'(bus.mul_valid), 0);
    chk("empty_c0", int'(bus.cur_c), 0);
    bus.cfg_num_a = A_W'(40);
    bus.start = 1'b1;
    cycle();
    chk("empty_c1", int'(bus.cur_c), 1);
    cycle();
    bus.start = 1'b0;
    chk("empty_c2", int'(bus.cur_c), 2);
    chk("start_ignored", int'(bus.remain_a), 0);
    cycle();
    chk("empty_to_wb", int'(bus.state), 3);
    finish_wb(4);

    // Reset in the middle of COMPUTE abandons the layer.
    bus.mul_ready = 1'b1;
    begin_layer(1, 2, 20, 20);
    bus.dram_last = 1'b1;
    cycle();
    bus.dram_last = 1'b0;
    cycle(); cycle();
    chk("pre_rst_a", int'(bus.cur_a), 8);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_state", int'(bus.state), 0);
    chk("midrst_layer", int'(bus.cur_layer), 0);
    chk("midrst_a", int'(bus.cur_a), 0);
    chk("midrst_remain_a", int'(bus.remain_a), 0);
    chk("midrst_busy", int'(bus.busy), 0);

    // Random traffic; the per-cycle compare process does the checking.
    for (int n = 0; n < 4000; n++) begin
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.cfg_num_k = K_W'($urandom_range(1, MAX_K));
      bus.cfg_num_c = C_W'($urandom_range(1, MAX_C));
      bus.cfg_num_a = ($urandom_range(0, 5) == 0) ? A_W'(0) : A_W'($urandom_range(1, MAX_A));
      bus.cfg_num_w = ($urandom_range(0, 5) == 0) ? W_W'(0) : W_W'($urandom_range(1, MAX_W));
      bus.dram_last = ($urandom_range(0, 1) == 1);
      bus.ppu_last  = ($urandom_range(0, 1) == 1);
      bus.mul_ready = ($urandom_range(0, 9) < 7);
      rst           = ($urandom_range(0, 599) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.start = 1'b0; bus.dram_last = 1'b0; bus.ppu_last = 1'b0;
    cycle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
